// File: rtl/bus_burst_driver.sv
// Push-button burst transaction generator for bus bring-up: debounced start,
// incrementing-address write bursts or read-verify bursts with a watchdog.
module bus_burst_driver #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int COUNT_WIDTH     = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_btn,
    input  logic                   cfg_mode,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    input  logic [DATA_WIDTH-1:0]  cfg_seed,
    output logic [DATA_WIDTH-1:0]  d_wdata,
    input  logic [DATA_WIDTH-1:0]  d_rdata,
    output logic [ADDR_WIDTH-1:0]  d_addr,
    output logic                   d_valid,
    input  logic                   d_ready,
    output logic                   d_mode,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] error_count,
    output logic                   timeout,
    output logic [DATA_WIDTH-1:0]  last_rdata
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FIN
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_db_state;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_start;
    logic                   r_mode;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0]  r_seed;
    logic [COUNT_WIDTH-1:0] r_idx;
    logic [WD_W-1:0]        r_wdog;

    logic [COUNT_WIDTH-1:0] w_idx_next;
    logic [DATA_WIDTH-1:0]  w_pattern;
    logic [DATA_WIDTH-1:0]  w_next_pattern;
    logic [ADDR_WIDTH-1:0]  w_next_addr;
    logic                   w_wdog_expired;

    assign w_idx_next     = r_idx + 1'b1;
    assign w_pattern      = r_seed + DATA_WIDTH'(r_idx);
    assign w_next_pattern = r_seed + DATA_WIDTH'(w_idx_next);
    assign w_next_addr    = r_base + ADDR_WIDTH'(w_idx_next);
    assign w_wdog_expired = (r_wdog == WD_LAST);

    // The debounce counter only runs while the synchronized level disagrees
    // with the accepted state, so any bounce back restarts the hold period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_state <= 1'b0;
            r_db_cnt   <= '0;
            r_start    <= 1'b0;
        end else begin
            r_sync1 <= start_btn;
            r_sync2 <= r_sync1;
            r_start <= 1'b0;
            if (r_sync2 == r_db_state) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_state <= r_sync2;
                r_db_cnt   <= '0;
                r_start    <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_base      <= '0;
            r_count     <= '0;
            r_seed      <= '0;
            r_idx       <= '0;
            r_wdog      <= '0;
            d_valid     <= 1'b0;
            d_mode      <= 1'b0;
            d_addr      <= '0;
            d_wdata     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error_count <= '0;
            timeout     <= 1'b0;
            last_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_start) begin
                        r_mode      <= cfg_mode;
                        r_base      <= cfg_addr;
                        r_count     <= cfg_count;
                        r_seed      <= cfg_seed;
                        r_idx       <= '0;
                        error_count <= '0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                        if (cfg_count == '0) begin
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            d_valid <= 1'b1;
                            d_mode  <= cfg_mode;
                            d_addr  <= cfg_addr;
                            if (cfg_mode) d_wdata <= cfg_seed;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (d_ready) begin
                        d_valid <= 1'b0;
                        r_wdog  <= '0;
                        r_state <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (w_wdog_expired) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                        if (!d_ready) r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (d_ready) begin
                        if (!r_mode) begin
                            last_rdata <= d_rdata;
                            if (d_rdata != w_pattern && error_count != '1)
                                error_count <= error_count + 1'b1;
                        end
                        r_idx <= w_idx_next;
                        if (w_idx_next == r_count) begin
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            d_valid <= 1'b1;
                            d_addr  <= w_next_addr;
                            if (r_mode) d_wdata <= w_next_pattern;
                            r_state <= S_REQ;
                        end
                    end else if (w_wdog_expired) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_burst_driver.sv
// Directed bench for bus_burst_driver with a small bus master/memory model.
module tb_bus_burst_driver;

    localparam int DEB = 10;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_btn;
    logic        cfg_mode;
    logic [15:0] cfg_addr;
    logic [7:0]  cfg_count;
    logic [7:0]  cfg_seed;
    logic [7:0]  d_wdata;
    logic [7:0]  d_rdata;
    logic [15:0] d_addr;
    logic        d_valid;
    logic        d_ready;
    logic        d_mode;
    logic        busy;
    logic        done;
    logic [7:0]  error_count;
    logic        timeout;
    logic [7:0]  last_rdata;

    bus_burst_driver #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .COUNT_WIDTH(8),
        .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .cfg_mode(cfg_mode),
        .cfg_addr(cfg_addr), .cfg_count(cfg_count), .cfg_seed(cfg_seed),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_addr(d_addr), .d_valid(d_valid),
        .d_ready(d_ready), .d_mode(d_mode), .busy(busy), .done(done),
        .error_count(error_count), .timeout(timeout), .last_rdata(last_rdata)
    );

    always #5 clk = ~clk;

    // Master port model: takes a request, goes not-ready for a few cycles, then completes.
    logic        m_ready = 1'b1;
    logic [7:0]  m_rdata = 8'h00;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_addr = '0;
    logic        m_mode = 1'b0;
    logic [7:0]  m_wd = '0;
    logic [7:0]  mem [0:65535];
    logic [15:0] log_addr [0:255];
    logic [7:0]  log_data [0:255];
    logic        log_mode [0:255];
    int          acc_cnt = 0;
    int          hang_at = 0;
    logic        corrupt_en = 1'b0;
    logic [15:0] corrupt_addr = '0;

    assign d_ready = m_ready;
    assign d_rdata = m_rdata;

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_busy  <= 1'b0;
            m_rdata <= 8'h00;
        end else if (m_busy) begin
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end else if (!(hang_at != 0 && acc_cnt >= hang_at)) begin
                m_ready <= 1'b1;
                m_busy  <= 1'b0;
                if (m_mode) mem[m_addr] <= m_wd;
                else m_rdata <= (corrupt_en && m_addr == corrupt_addr) ? 8'h00 : mem[m_addr];
            end
        end else if (d_valid && m_ready) begin
            m_ready <= 1'b0;
            m_busy  <= 1'b1;
            m_cnt   <= 2;
            m_addr  <= d_addr;
            m_mode  <= d_mode;
            m_wd    <= d_wdata;
            log_addr[acc_cnt[7:0]] <= d_addr;
            log_data[acc_cnt[7:0]] <= d_wdata;
            log_mode[acc_cnt[7:0]] <= d_mode;
            acc_cnt <= acc_cnt + 1;
        end
    end

    int done_cnt = 0;
    int vld_cnt  = 0;
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (d_valid) vld_cnt <= vld_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic prev_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_hold();
        for (int k = 0; k < 3; k++) begin
            start_btn = 1'b1;
            repeat (2) @(negedge clk);
            start_btn = 1'b0;
            repeat (2) @(negedge clk);
        end
        start_btn = 1'b1;
    endtask

    task automatic release_btn();
        start_btn = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        prev_busy = busy;
        while (!seen && n < max_cyc) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                prev_busy = busy;
                n++;
            end
        end
        check({tag, "_done_seen"}, seen, 1'b1);
    endtask

    int a0, d0, v0, n;

    initial begin
        rst = 1'b1; start_btn = 1'b0;
        cfg_mode = 1'b0; cfg_addr = '0; cfg_count = '0; cfg_seed = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", d_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", d_addr, 16'h0000);
        check("rst_wdata", d_wdata, 8'h00);
        check("rst_errcnt", error_count, 8'h00);
        check("rst_timeout", timeout, 1'b0);
        check("rst_lastrd", last_rdata, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write burst
        cfg_mode = 1'b1; cfg_addr = 16'h0100; cfg_count = 8'd4; cfg_seed = 8'hA0;
        a0 = acc_cnt; d0 = done_cnt;
        press_hold();
        wait_done(300, "wr");
        check("wr_busy_at_done", busy, 1'b1);
        check("wr_errcnt", error_count, 8'h00);
        @(negedge clk);
        check("wr_busy_after", busy, 1'b0);
        check("wr_done_width", done, 1'b0);
        release_btn();
        check("wr_ntrans", acc_cnt - a0, 4);
        check("wr_ndone", done_cnt - d0, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr_addr%0d", i), log_addr[(a0 + i) % 256], 32'h0100 + i);
            check($sformatf("wr_data%0d", i), log_data[(a0 + i) % 256], 32'hA0 + i);
            check($sformatf("wr_mode%0d", i), log_mode[(a0 + i) % 256], 1'b1);
        end

        // Read-verify of the same region
        cfg_mode = 1'b0;
        a0 = acc_cnt;
        press_hold();
        wait_done(300, "rd");
        check("rd_errcnt", error_count, 8'h00);
        check("rd_lastrd", last_rdata, 8'hA3);
        release_btn();
        check("rd_ntrans", acc_cnt - a0, 4);
        check("rd_mode0", log_mode[a0 % 256], 1'b0);
        check("rd_addr3", log_addr[(a0 + 3) % 256], 16'h0103);

        // Read-verify with one corrupted location
        corrupt_addr = 16'h0102; corrupt_en = 1'b1;
        press_hold();
        wait_done(300, "rdc");
        check("rdc_errcnt", error_count, 8'h01);
        check("rdc_lastrd", last_rdata, 8'hA3);
        release_btn();
        corrupt_en = 1'b0;

        // Address and pattern wrap
        cfg_mode = 1'b1; cfg_addr = 16'hFFFE; cfg_count = 8'd3; cfg_seed = 8'hFF;
        a0 = acc_cnt;
        press_hold();
        wait_done(300, "wrap");
        release_btn();
        check("wrap_ntrans", acc_cnt - a0, 3);
        check("wrap_addr0", log_addr[a0 % 256], 16'hFFFE);
        check("wrap_addr1", log_addr[(a0 + 1) % 256], 16'hFFFF);
        check("wrap_addr2", log_addr[(a0 + 2) % 256], 16'h0000);
        check("wrap_data0", log_data[a0 % 256], 8'hFF);
        check("wrap_data1", log_data[(a0 + 1) % 256], 8'h00);
        check("wrap_data2", log_data[(a0 + 2) % 256], 8'h01);
        cfg_mode = 1'b0;
        press_hold();
        wait_done(300, "wraprd");
        check("wraprd_errcnt", error_count, 8'h00);
        check("wraprd_lastrd", last_rdata, 8'h01);
        release_btn();

        // Watchdog: slave hangs on transfer 2 of 5
        cfg_mode = 1'b1; cfg_addr = 16'h0200; cfg_count = 8'd5; cfg_seed = 8'h10;
        a0 = acc_cnt; d0 = done_cnt;
        hang_at = a0 + 2;
        press_hold();
        wait_done(400, "wd");
        check("wd_timeout", timeout, 1'b1);
        v0 = vld_cnt;
        release_btn();
        repeat (20) @(negedge clk);
        check("wd_no_valid", vld_cnt - v0, 0);
        check("wd_ntrans", acc_cnt - a0, 2);
        check("wd_ndone", done_cnt - d0, 1);
        check("wd_sticky", timeout, 1'b1);
        hang_at = 0;
        repeat (10) @(negedge clk);

        // Next start clears the timeout flag
        cfg_addr = 16'h0400; cfg_count = 8'd1; cfg_seed = 8'h77;
        a0 = acc_cnt;
        press_hold();
        wait_done(300, "clr");
        check("clr_timeout", timeout, 1'b0);
        release_btn();
        check("clr_ntrans", acc_cnt - a0, 1);
        check("clr_data", log_data[a0 % 256], 8'h77);

        // Long burst with a second press while busy
        cfg_addr = 16'h0300; cfg_count = 8'd20; cfg_seed = 8'h40;
        a0 = acc_cnt; d0 = done_cnt;
        press_hold();
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("start_latency_ok", (busy && n <= DEB + 4), 1'b1);
        release_btn();
        press_hold();
        repeat (20) @(negedge clk);
        release_btn();
        check("bp_still_busy", busy, 1'b1);
        wait_done(400, "bp");
        repeat (60) @(negedge clk);
        check("bp_ndone", done_cnt - d0, 1);
        check("bp_ntrans", acc_cnt - a0, 20);
        check("bp_last_addr", log_addr[(a0 + 19) % 256], 16'h0313);
        check("bp_last_data", log_data[(a0 + 19) % 256], 8'h53);

        // Empty burst
        cfg_count = 8'd0;
        v0 = vld_cnt; d0 = done_cnt;
        press_hold();
        wait_done(100, "empty");
        check("empty_prev_busy", prev_busy, 1'b0);
        check("empty_busy", busy, 1'b1);
        @(negedge clk);
        check("empty_busy_after", busy, 1'b0);
        release_btn();
        check("empty_no_valid", vld_cnt - v0, 0);
        check("empty_ndone", done_cnt - d0, 1);

        // Reset in the middle of a burst
        cfg_mode = 1'b1; cfg_addr = 16'h0500; cfg_count = 8'd10; cfg_seed = 8'h33;
        press_hold();
        n = 0;
        while (!d_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("mid_valid_seen", d_valid, 1'b1);
        rst = 1'b1;
        #1;
        d0 = done_cnt;
        check("mid_valid", d_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_addr", d_addr, 16'h0000);
        check("mid_wdata", d_wdata, 8'h00);
        check("mid_mode", d_mode, 1'b0);
        check("mid_lastrd", last_rdata, 8'h00);
        start_btn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("mid_no_done", done_cnt - d0, 0);
        check("mid_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
        $fatal(1);
    end

endmodule
